mig1_fetch: RTL and testbench

Instruction fetch stage for the Mig1 core; sits between the SimRAM read port and the core's decode stage.
- Owns the PC and issues word reads to RAM.
- Buffers returned words in a small FIFO tagged with their PC and presents them to decode over a valid/ready handshake.
- Supports redirect (branch/jump) and halt.

---
 rtl/mig1_pkg.sv | 27 ++
 rtl/mig1_fetch_fifo.sv | 69 ++++++
 rtl/mig1_fetch.sv | 135 +++++++++++++
 tb/tb_mig1_fetch.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mig1_pkg.sv
// Shared types and constants for the Mig1 core front end.
// Fetch FIFO entries are built from these fixed-width types.
package mig1_pkg;

   localparam int unsigned MIG1_DATA_WIDTH = 32;
   localparam int unsigned MIG1_ADDR_WIDTH = 8;

   typedef logic [MIG1_DATA_WIDTH-1:0] mig1_word_t;
   typedef logic [MIG1_ADDR_WIDTH-1:0] mig1_addr_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   typedef struct packed {
      mig1_addr_t pc;
      mig1_word_t inst;
   } fetch_entry_t;

   // Word-address increment; wraps modulo 2^MIG1_ADDR_WIDTH.
   function automatic mig1_addr_t pc_inc(input mig1_addr_t pc);
      return pc + mig1_addr_t'(1);
   endfunction

endpackage

// File: rtl/mig1_fetch_fifo.sv
// Synchronous instruction buffer of fetch_entry_t with push, pop and flush.
// Depth must be a power of two, minimum 2; flush takes priority over push/pop.
module mig1_fetch_fifo
   import mig1_pkg::*;
#(
   parameter int unsigned Depth = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  fetch_entry_t             push_data_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output logic [$clog2(Depth):0]   count_o,
   output fetch_entry_t             head_o
);

   localparam int unsigned PtrW = $clog2(Depth);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] Full = CntW'(Depth);

   fetch_entry_t mem_q [Depth];

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            do_push, do_pop;

   assign do_pop  = pop_i && (count_q != '0);
   // A push into a full buffer is only legal when the head leaves in the same cycle.
   assign do_push = push_i && ((count_q != Full) || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
         count_d = count_q + CntW'(do_push) - CntW'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/mig1_fetch.sv
// Mig1 instruction fetch: owns the PC, issues SimRAM reads, buffers tagged words for decode.
// Optional performance counters under `MIG1_FETCH_PERF_EN. DATA/ADDR_WIDTH must match mig1_pkg.
module mig1_fetch
   import mig1_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = MIG1_DATA_WIDTH,
   parameter int unsigned ADDR_WIDTH = MIG1_ADDR_WIDTH,
   parameter int unsigned RESET_PC   = 0,
   parameter int unsigned FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  halt,
   input  logic                  redirect_valid,
   input  logic [ADDR_WIDTH-1:0] redirect_pc,
   output logic                  ram_rd_en,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic                  inst_valid,
   output logic [DATA_WIDTH-1:0] inst_data,
   output logic [ADDR_WIDTH-1:0] inst_pc,
   input  logic                  inst_ready,
`ifdef MIG1_FETCH_PERF_EN
   output logic [31:0]           perf_fetch_cnt,
   output logic [31:0]           perf_stall_cnt,
`endif
   output logic                  busy
);

   localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned CrW  = CntW + 1;
   localparam logic [CrW-1:0] DepthC = CrW'(FIFO_DEPTH);

   fetch_state_t state_q, state_d;
   mig1_addr_t   pc_q, pc_d;
   mig1_addr_t   tag_q, tag_d;
   logic         inflight_q;

   logic [CntW-1:0] count;
   logic [CrW-1:0]  credit;
   fetch_entry_t    head, push_entry;
   logic            redirect_en, pop, push, issue;

   assign redirect_en = redirect_valid && (state_q != IDLE);
   assign pop         = inst_valid && inst_ready;
   // Data returning in a redirect cycle belongs to the old stream and is dropped.
   assign push        = inflight_q && !redirect_en;
   assign push_entry  = '{pc: tag_q, inst: ram_rd_data};

   // Slots already spoken for once this cycle's pop retires.
   assign credit = {1'b0, count} + CrW'(inflight_q) - CrW'(pop);
   assign issue  = (state_q == RUN) && !halt && !redirect_en && (credit < DepthC);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (halt) state_d = HALTED;
         HALTED:  if (!halt) state_d = RUN;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pc_d  = pc_q;
      tag_d = tag_q;
      if (redirect_en) begin
         pc_d = redirect_pc;
      end else if (issue) begin
         pc_d  = pc_inc(pc_q);
         tag_d = pc_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         pc_q       <= mig1_addr_t'(RESET_PC);
         tag_q      <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         tag_q      <= tag_d;
         inflight_q <= issue;
      end
   end

   mig1_fetch_fifo #(
      .Depth (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .flush_i     (redirect_en),
      .count_o     (count),
      .head_o      (head)
   );

   assign ram_rd_en   = issue;
   assign ram_rd_addr = issue ? pc_q : '0;
   assign inst_valid  = (count != '0);
   assign inst_data   = inst_valid ? head.inst : '0;
   assign inst_pc     = inst_valid ? head.pc : '0;
   assign busy        = (state_q == RUN) || inflight_q;

`ifdef MIG1_FETCH_PERF_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] stall_cnt_q, stall_cnt_d;

   always_comb begin
      fetch_cnt_d = fetch_cnt_q;
      stall_cnt_d = stall_cnt_q;
      if (pop) fetch_cnt_d = fetch_cnt_q + 32'd1;
      if ((state_q == RUN) && !issue) stall_cnt_d = stall_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else begin
         fetch_cnt_q <= fetch_cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign perf_fetch_cnt = fetch_cnt_q;
   assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mig1_fetch.sv
// Randomized bench for mig1_fetch against a transaction-level model of the fetch stream.
module tb_mig1_fetch;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        halt = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [7:0]  redirect_pc = '0;
   logic        inst_ready = 1'b0;
   logic        ram_rd_en;
   logic [7:0]  ram_rd_addr;
   logic [31:0] ram_rd_data = '0;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [7:0]  inst_pc;
   logic        busy;
`ifdef MIG1_FETCH_PERF_EN
   logic [31:0] perf_fetch_cnt;
   logic [31:0] perf_stall_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;

   // Model: 0 idle, 1 run, 2 halted; queue holds PCs issued and not yet delivered.
   int         m_state = 0;
   logic [7:0] m_pc = 8'h00;
   int         m_b = 0;
   bit         m_infl = 1'b0;
   logic [7:0] m_q[$];
   int         m_fetch = 0;
   int         m_stall = 0;

   mig1_fetch dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .halt           (halt),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .ram_rd_en      (ram_rd_en),
      .ram_rd_addr    (ram_rd_addr),
      .ram_rd_data    (ram_rd_data),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready),
`ifdef MIG1_FETCH_PERF_EN
      .perf_fetch_cnt (perf_fetch_cnt),
      .perf_stall_cnt (perf_stall_cnt),
`endif
      .busy           (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ram_word(input logic [7:0] a);
      return 32'h1000_0000 + {24'h0, a};
   endfunction

   // SimRAM: one-cycle read latency, junk when not reading.
   always @(posedge clk) begin
      ram_rd_data <= ram_rd_en ? ram_word(ram_rd_addr) : 32'hDEAD_BEEF;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = 0;
      m_pc    = 8'h00;
      m_b     = 0;
      m_infl  = 1'b0;
      m_q.delete();
      m_fetch = 0;
      m_stall = 0;
   endtask

   task automatic cycle(input logic st, input logic hl, input logic rv,
                        input logic [7:0] rpc, input logic rdy);
      bit redir, pop, exp_en;
      @(negedge clk);
      start = st;
      halt = hl;
      redirect_valid = rv;
      redirect_pc = rpc;
      inst_ready = rdy;
      #1;
      redir  = rv && (m_state != 0);
      pop    = (m_b > 0) && rdy;
      exp_en = (m_state == 1) && !hl && !redir && ((m_b + int'(m_infl) - int'(pop)) < DEPTH);
      check("rd_en", {31'h0, ram_rd_en}, {31'h0, exp_en});
      if (exp_en) check("rd_addr", {24'h0, ram_rd_addr}, {24'h0, m_pc});
      check("inst_valid", {31'h0, inst_valid}, {31'h0, m_b > 0});
      if (m_b > 0 && m_q.size() > 0) begin
         check("inst_pc", {24'h0, inst_pc}, {24'h0, m_q[0]});
         check("inst_data", inst_data, ram_word(m_q[0]));
      end
      check("busy", {31'h0, busy}, {31'h0, (m_state == 1) || m_infl});
      if (pop) begin
         void'(m_q.pop_front());
         m_fetch++;
      end
      if (m_state == 1 && !exp_en) m_stall++;
      if (redir) begin
         m_q.delete();
         m_b  = 0;
         m_pc = rpc;
      end else begin
         m_b = m_b - int'(pop) + int'(m_infl);
      end
      if (exp_en) begin
         m_q.push_back(m_pc);
         m_pc = m_pc + 8'd1;
      end
      m_infl = exp_en;
      case (m_state)
         0: if (st) m_state = 1;
         1: if (hl) m_state = 2;
         2: if (!hl) m_state = 1;
         default: m_state = 0;
      endcase
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_rd_en"}, {31'h0, ram_rd_en}, 32'h0);
      check({tag, "_rd_addr"}, {24'h0, ram_rd_addr}, 32'h0);
      check({tag, "_valid"}, {31'h0, inst_valid}, 32'h0);
      check({tag, "_data"}, inst_data, 32'h0);
      check({tag, "_pc"}, {24'h0, inst_pc}, 32'h0);
      check({tag, "_busy"}, {31'h0, busy}, 32'h0);
   endtask

   task automatic mid_reset();
      @(negedge clk);
      start = 1'b0;
      halt = 1'b0;
      redirect_valid = 1'b0;
`ifdef MIG1_FETCH_PERF_EN
      check("perf_fetch_pre", perf_fetch_cnt, m_fetch);
      check("perf_stall_pre", perf_stall_cnt, m_stall);
`endif
      #2 rst = 1'b1;
      #1 check_outputs_zero("midrst");
`ifdef MIG1_FETCH_PERF_EN
      check("perf_fetch_rst", perf_fetch_cnt, 32'h0);
      check("perf_stall_rst", perf_stall_cnt, 32'h0);
`endif
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   logic       hl_lvl;
   logic [7:0] r;

   initial begin
      #1 rst = 1'b1;
      #1 check_outputs_zero("reset");
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      model_reset();

      // Idle with a redirect that must be ignored, then start and stream.
      cycle(0, 0, 0, 8'h00, 1);
      cycle(0, 0, 1, 8'h55, 1);
      cycle(1, 0, 0, 8'h00, 1);
      repeat (12) cycle(0, 0, 0, 8'h00, 1);
      // Backpressure for five cycles.
      repeat (5) cycle(0, 0, 0, 8'h00, 0);
      repeat (8) cycle(0, 0, 0, 8'h00, 1);
      // Redirect with buffered and in-flight words.
      cycle(0, 0, 0, 8'h00, 0);
      cycle(0, 0, 1, 8'h40, 0);
      repeat (8) cycle(0, 0, 0, 8'h00, 1);
      // PC wrap.
      cycle(0, 0, 1, 8'hFE, 1);
      repeat (8) cycle(0, 0, 0, 8'h00, 1);
      // Halt for four cycles, then resume.
      repeat (4) cycle(0, 1, 0, 8'h00, 1);
      repeat (6) cycle(0, 0, 0, 8'h00, 1);
      // Halt and redirect together.
      cycle(0, 1, 1, 8'h80, 1);
      repeat (3) cycle(0, 1, 0, 8'h00, 1);
      repeat (6) cycle(0, 0, 0, 8'h00, 1);
      // Async reset mid-stream; start + redirect in IDLE: start wins.
      mid_reset();
      repeat (3) cycle(0, 0, 1, 8'h99, 1);
      cycle(1, 0, 1, 8'h33, 1);
      repeat (6) cycle(0, 0, 0, 8'h00, 1);

      hl_lvl = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) mid_reset();
         if (($urandom % 12) == 0) hl_lvl = !hl_lvl;
         r = 8'($urandom);
         if (($urandom % 4) == 0) r = 8'hFC | 8'($urandom % 4);
         cycle((m_state == 0) && (($urandom % 3) == 0), hl_lvl, ($urandom % 20) == 0, r,
               ($urandom % 4) != 0);
      end
      mid_reset();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
